// File: rtl/exec_unit_pkg.sv
// Opcode map and FSM encoding shared by the registered execution unit and its bench.
package exec_unit_pkg;

    typedef enum logic [1:0] {
        EU_IDLE = 2'd0,
        EU_MUL  = 2'd1,
        EU_DIV  = 2'd2
    } eu_state_t;

    localparam logic [5:0] OP_LUI    = 6'd1;
    localparam logic [5:0] OP_AUIPC  = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_JALR   = 6'd4;
    localparam logic [5:0] OP_BEQ    = 6'd5;
    localparam logic [5:0] OP_BNE    = 6'd6;
    localparam logic [5:0] OP_BLT    = 6'd7;
    localparam logic [5:0] OP_BGE    = 6'd8;
    localparam logic [5:0] OP_BLTU   = 6'd9;
    localparam logic [5:0] OP_BGEU   = 6'd10;
    localparam logic [5:0] OP_ADDI   = 6'd11;
    localparam logic [5:0] OP_SLTI   = 6'd12;
    localparam logic [5:0] OP_SLTIU  = 6'd13;
    localparam logic [5:0] OP_XORI   = 6'd14;
    localparam logic [5:0] OP_ORI    = 6'd15;
    localparam logic [5:0] OP_ANDI   = 6'd16;
    localparam logic [5:0] OP_SLLI   = 6'd17;
    localparam logic [5:0] OP_SRLI   = 6'd18;
    localparam logic [5:0] OP_SRAI   = 6'd19;
    localparam logic [5:0] OP_ADD    = 6'd20;
    localparam logic [5:0] OP_SUB    = 6'd21;
    localparam logic [5:0] OP_SLL    = 6'd22;
    localparam logic [5:0] OP_SLT    = 6'd23;
    localparam logic [5:0] OP_SLTU   = 6'd24;
    localparam logic [5:0] OP_XOR    = 6'd25;
    localparam logic [5:0] OP_SRL    = 6'd26;
    localparam logic [5:0] OP_SRA    = 6'd27;
    localparam logic [5:0] OP_OR     = 6'd28;
    localparam logic [5:0] OP_AND    = 6'd29;
    localparam logic [5:0] OP_MUL    = 6'd30;
    localparam logic [5:0] OP_MULH   = 6'd31;
    localparam logic [5:0] OP_MULHSU = 6'd32;
    localparam logic [5:0] OP_MULHU  = 6'd33;
    localparam logic [5:0] OP_DIV    = 6'd34;
    localparam logic [5:0] OP_DIVU   = 6'd35;
    localparam logic [5:0] OP_REM    = 6'd36;
    localparam logic [5:0] OP_REMU   = 6'd37;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/exec_unit_div_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per enabled cycle.
// done marks the edge that retires the last bit; quotient/remainder show the post-step values.
module exec_unit_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        // A set top bit of diff means the trial subtraction borrowed: restore.
        if (diff[XLEN]) begin
            remainder = rem_sh[XLEN-1:0];
            quotient  = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            remainder = diff[XLEN-1:0];
            quotient  = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (en) begin
            if (abort) begin
                busy_q <= 1'b0;
            end else if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(XLEN);
            end else if (busy_q) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en && start && !abort) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (en && busy_q) begin
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/exec_unit.sv
// Registered RV32I/RV32M execution unit between the arithmetic RS and the CDB.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             RS_sgn,
    output logic             RS_ready,
    input  logic [5:0]       RS_opcode,
    input  logic [XLEN-1:0]  lhs,
    input  logic [XLEN-1:0]  rhs,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [ROB_W-1:0] ROB_entry,
    output logic             CDB_sgn,
    output logic [ROB_W-1:0] CDB_ROB_name,
    output logic [XLEN-1:0]  result,
    output logic [XLEN-1:0]  CDB_pc_init,
    output logic [XLEN-1:0]  CDB_pc
);
    localparam int   SH_W      = $clog2(XLEN);
    localparam int   CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic MUL_MULTI = (MUL_LAT > 1);

    eu_state_t state_q, state_d;

    logic                   accept, fire;
    logic [XLEN-1:0]        fire_res, fire_npc, fire_pc, imm_res;
    logic [ROB_W-1:0]       fire_tag;
    logic signed [XLEN-1:0] lhs_s, rhs_s, imm_s;
    logic [SH_W-1:0]        shamt_r, shamt_i;
    logic [XLEN-1:0]        pc_plus4, alu_res, alu_npc;
    logic                   br_taken;
    logic                   mul_op, div_op, div_signed, div_rem_op, div_zero, div_ovf, div_corner;
    logic [XLEN-1:0]        div_corner_res, dvd_abs, dvs_abs;
    logic [2*XLEN-1:0]      mul_a, mul_b, prod;
    logic                   div_start, div_busy, div_done;
    logic [XLEN-1:0]        div_quo, div_rem;

    logic [2*XLEN-1:0]      prod_q;
    logic                   mul_hi_q, div_neg_q, div_rem_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ROB_W-1:0]       tag_q;
    logic [XLEN-1:0]        pc_q, npc_q;

    function automatic logic [XLEN-1:0] zext1(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
        return neg ? ('0 - mag) : mag;
    endfunction

    assign lhs_s    = lhs;
    assign rhs_s    = rhs;
    assign imm_s    = imm;
    assign shamt_r  = rhs[SH_W-1:0];
    assign shamt_i  = imm[SH_W-1:0];
    assign pc_plus4 = pc + XLEN'(4);
    assign accept   = rdy && RS_sgn && RS_ready && !clear;

    always_comb begin
        alu_res  = '0;
        alu_npc  = pc_plus4;
        br_taken = 1'b0;
        case (RS_opcode)
            OP_LUI:   alu_res = imm;
            OP_AUIPC: alu_res = pc + imm;
            OP_JAL:   begin alu_res = pc_plus4; alu_npc = pc + imm; end
            OP_JALR:  begin alu_res = pc_plus4; alu_npc = (lhs + imm) & {{(XLEN-1){1'b1}}, 1'b0}; end
            OP_BEQ:   br_taken = (lhs == rhs);
            OP_BNE:   br_taken = (lhs != rhs);
            OP_BLT:   br_taken = (lhs_s < rhs_s);
            OP_BGE:   br_taken = (lhs_s >= rhs_s);
            OP_BLTU:  br_taken = (lhs < rhs);
            OP_BGEU:  br_taken = (lhs >= rhs);
            OP_ADDI:  alu_res = lhs + imm;
            OP_SLTI:  alu_res = zext1(lhs_s < imm_s);
            OP_SLTIU: alu_res = zext1(lhs < imm);
            OP_XORI:  alu_res = lhs ^ imm;
            OP_ORI:   alu_res = lhs | imm;
            OP_ANDI:  alu_res = lhs & imm;
            OP_SLLI:  alu_res = lhs << shamt_i;
            OP_SRLI:  alu_res = lhs >> shamt_i;
            OP_SRAI:  alu_res = lhs_s >>> shamt_i;
            OP_ADD:   alu_res = lhs + rhs;
            OP_SUB:   alu_res = lhs - rhs;
            OP_SLL:   alu_res = lhs << shamt_r;
            OP_SLT:   alu_res = zext1(lhs_s < rhs_s);
            OP_SLTU:  alu_res = zext1(lhs < rhs);
            OP_XOR:   alu_res = lhs ^ rhs;
            OP_SRL:   alu_res = lhs >> shamt_r;
            OP_SRA:   alu_res = lhs_s >>> shamt_r;
            OP_OR:    alu_res = lhs | rhs;
            OP_AND:   alu_res = lhs & rhs;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin end
            default:  alu_npc = '0;
        endcase
        if (RS_opcode inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
            alu_res = zext1(br_taken);
            if (br_taken) alu_npc = pc + imm;
        end
    end

    always_comb begin
        mul_op     = is_mul_op(RS_opcode);
        div_op     = is_div_op(RS_opcode);
        div_signed = (RS_opcode == OP_DIV) || (RS_opcode == OP_REM);
        div_rem_op = (RS_opcode == OP_REM) || (RS_opcode == OP_REMU);
        div_zero   = (rhs == '0);
        div_ovf    = div_signed && (lhs == {1'b1, {(XLEN-1){1'b0}}}) && (rhs == '1);
        div_corner = div_zero || div_ovf;
        if (div_zero) div_corner_res = div_rem_op ? lhs : '1;
        else          div_corner_res = div_rem_op ? '0 : lhs;
        dvd_abs    = (div_signed && lhs[XLEN-1]) ? ('0 - lhs) : lhs;
        dvs_abs    = (div_signed && rhs[XLEN-1]) ? ('0 - rhs) : rhs;
        // Sign/zero extension to full product width makes one unsigned multiply serve all four forms.
        mul_a      = {{XLEN{((RS_opcode == OP_MULH) || (RS_opcode == OP_MULHSU)) && lhs[XLEN-1]}}, lhs};
        mul_b      = {{XLEN{(RS_opcode == OP_MULH) && rhs[XLEN-1]}}, rhs};
        prod       = mul_a * mul_b;
        if (mul_op)      imm_res = (RS_opcode == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (div_op) imm_res = div_corner_res;
        else             imm_res = alu_res;
    end

    assign div_start = accept && div_op && !div_corner;

    exec_unit_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .abort     (clear),
        .start     (div_start),
        .dividend  (dvd_abs),
        .divisor   (dvs_abs),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst)      state_q <= EU_IDLE;
        else if (rdy) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = EU_IDLE;
        end else begin
            case (state_q)
                EU_IDLE: begin
                    if (accept && mul_op && MUL_MULTI)         state_d = EU_MUL;
                    else if (accept && div_op && !div_corner)  state_d = EU_DIV;
                end
                EU_MUL:  if (cnt_q == CNT_W'(1)) state_d = EU_IDLE;
                EU_DIV:  if (div_done || !div_busy) state_d = EU_IDLE;
                default: state_d = EU_IDLE;
            endcase
        end
    end

    always_comb begin
        RS_ready = (state_q == EU_IDLE) && !rst;
    end

    always_comb begin
        fire     = 1'b0;
        fire_tag = ROB_entry;
        fire_pc  = pc;
        fire_npc = alu_npc;
        fire_res = imm_res;
        case (state_q)
            EU_IDLE: fire = accept && !(mul_op && MUL_MULTI) && !(div_op && !div_corner);
            EU_MUL: begin
                fire     = (cnt_q == CNT_W'(1));
                fire_tag = tag_q;
                fire_pc  = pc_q;
                fire_npc = npc_q;
                fire_res = mul_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
            end
            EU_DIV: begin
                fire     = div_done;
                fire_tag = tag_q;
                fire_pc  = pc_q;
                fire_npc = npc_q;
                fire_res = apply_sign(div_rem_q ? div_rem : div_quo, div_neg_q);
            end
            default: fire = 1'b0;
        endcase
    end

    // Accept stage: capture everything a multi-cycle op needs at retirement.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q     <= ROB_entry;
            pc_q      <= pc;
            npc_q     <= pc_plus4;
            prod_q    <= prod;
            mul_hi_q  <= (RS_opcode != OP_MUL);
            div_rem_q <= div_rem_op;
            div_neg_q <= div_signed && (div_rem_op ? lhs[XLEN-1] : (lhs[XLEN-1] ^ rhs[XLEN-1]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rdy) begin
            if (accept && mul_op)                        cnt_q <= CNT_W'(MUL_LAT - 1);
            else if (state_q == EU_MUL && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
        end
    end

    // CDB stage: one-cycle pulse per result; clear suppresses anything retiring this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            CDB_sgn      <= 1'b0;
            CDB_ROB_name <= '0;
            result       <= '0;
            CDB_pc_init  <= '0;
            CDB_pc       <= '0;
        end else if (rdy) begin
            CDB_sgn <= 1'b0;
            if (!clear && fire) begin
                CDB_sgn      <= 1'b1;
                CDB_ROB_name <= fire_tag;
                result       <= fire_res;
                CDB_pc_init  <= fire_pc;
                CDB_pc       <= fire_npc;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized and directed bench for exec_unit against a plain-arithmetic reference model.
module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int XLEN    = 32;
    localparam int ROB_W   = 4;
    localparam int MUL_LAT = 3;

    logic             clk = 1'b0;
    logic             rst, rdy, clear, RS_sgn;
    logic             RS_ready;
    logic [5:0]       RS_opcode;
    logic [XLEN-1:0]  lhs, rhs, imm, pc;
    logic [ROB_W-1:0] ROB_entry;
    logic             CDB_sgn;
    logic [ROB_W-1:0] CDB_ROB_name;
    logic [XLEN-1:0]  result, CDB_pc_init, CDB_pc;

    int checks   = 0;
    int failures = 0;

    exec_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear),
        .RS_sgn       (RS_sgn),
        .RS_ready     (RS_ready),
        .RS_opcode    (RS_opcode),
        .lhs          (lhs),
        .rhs          (rhs),
        .imm          (imm),
        .pc           (pc),
        .ROB_entry    (ROB_entry),
        .CDB_sgn      (CDB_sgn),
        .CDB_ROB_name (CDB_ROB_name),
        .result       (result),
        .CDB_pc_init  (CDB_pc_init),
        .CDB_pc       (CDB_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] i, input logic [31:0] p,
                                  output logic [31:0] res, output logic [31:0] npc, output int lat);
        longint      sa, sb, sp;
        logic [63:0] up;
        logic [4:0]  sh_r, sh_i;
        logic        t;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sh_r = b[4:0];
        sh_i = i[4:0];
        res  = '0;
        npc  = p + 32'd4;
        lat  = 1;
        t    = 1'b0;
        case (op)
            OP_LUI:    res = i;
            OP_AUIPC:  res = p + i;
            OP_JAL:    begin res = p + 32'd4; npc = p + i; end
            OP_JALR:   begin res = p + 32'd4; npc = (a + i) & 32'hFFFF_FFFE; end
            OP_BEQ:    t = (a == b);
            OP_BNE:    t = (a != b);
            OP_BLT:    t = (sa < sb);
            OP_BGE:    t = (sa >= sb);
            OP_BLTU:   t = (a < b);
            OP_BGEU:   t = (a >= b);
            OP_ADDI:   res = a + i;
            OP_SLTI:   res = {31'b0, $signed(a) < $signed(i)};
            OP_SLTIU:  res = {31'b0, a < i};
            OP_XORI:   res = a ^ i;
            OP_ORI:    res = a | i;
            OP_ANDI:   res = a & i;
            OP_SLLI:   res = a << sh_i;
            OP_SRLI:   res = a >> sh_i;
            OP_SRAI:   res = $unsigned($signed(a) >>> sh_i);
            OP_ADD:    res = a + b;
            OP_SUB:    res = a - b;
            OP_SLL:    res = a << sh_r;
            OP_SLT:    res = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:   res = {31'b0, a < b};
            OP_XOR:    res = a ^ b;
            OP_SRL:    res = a >> sh_r;
            OP_SRA:    res = $unsigned($signed(a) >>> sh_r);
            OP_OR:     res = a | b;
            OP_AND:    res = a & b;
            OP_MUL:    begin res = a * b; lat = MUL_LAT; end
            OP_MULH:   begin sp = sa * sb; res = sp[63:32]; lat = MUL_LAT; end
            OP_MULHSU: begin sp = sa * longint'({32'b0, b}); res = sp[63:32]; lat = MUL_LAT; end
            OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; res = up[63:32]; lat = MUL_LAT; end
            OP_DIV: begin
                if (b == 0) res = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
                else begin sp = sa / sb; res = sp[31:0]; lat = XLEN + 1; end
            end
            OP_DIVU: begin
                if (b == 0) res = '1;
                else begin res = a / b; lat = XLEN + 1; end
            end
            OP_REM: begin
                if (b == 0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
                else begin sp = sa % sb; res = sp[31:0]; lat = XLEN + 1; end
            end
            OP_REMU: begin
                if (b == 0) res = a;
                else begin res = a % b; lat = XLEN + 1; end
            end
            default: begin res = '0; npc = '0; end
        endcase
        if (op >= OP_BEQ && op <= OP_BGEU) begin
            res = {31'b0, t};
            if (t) npc = p + i;
        end
    endfunction

    // Issue one op, wait for its CDB pulse and check latency, payload and ready behaviour.
    task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] p, input logic [3:0] tag,
                          input logic [31:0] eres, input logic [31:0] enpc, input int elat, input int stall_at);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        chk({nm, "_ready_pre"}, 32'(RS_ready), 32'd1);
        RS_opcode = op; lhs = a; rhs = b; imm = i; pc = p; ROB_entry = tag; RS_sgn = 1'b1;
        @(posedge clk); #1;
        RS_sgn = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (stall_at > 0 && cyc == stall_at)     rdy = 1'b0;
            if (stall_at > 0 && cyc == stall_at + 5) rdy = 1'b1;
            if (cyc == 1 && elat > 1) chk({nm, "_ready_busy"}, 32'(RS_ready), 32'd0);
            if (CDB_sgn) seen = 1'b1;
        end
        rdy = 1'b1;
        chk({nm, "_seen"}, 32'(seen), 32'd1);
        chk({nm, "_lat"}, cyc, elat);
        chk({nm, "_res"}, result, eres);
        chk({nm, "_npc"}, CDB_pc, enpc);
        chk({nm, "_pcinit"}, CDB_pc_init, p);
        chk({nm, "_tag"}, 32'(CDB_ROB_name), 32'(tag));
        chk({nm, "_ready_done"}, 32'(RS_ready), 32'd1);
        @(negedge clk);
        chk({nm, "_pulse_end"}, 32'(CDB_sgn), 32'd0);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b, i, p, er, en;
        logic [3:0]  tg;
        int          el, cnt;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0; RS_sgn = 1'b0;
        RS_opcode = '0; lhs = '0; rhs = '0; imm = '0; pc = '0; ROB_entry = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(RS_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sgn", 32'(CDB_sgn), 32'd0);
        chk("rst_tag", 32'(CDB_ROB_name), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_pcinit", CDB_pc_init, 32'd0);
        chk("rst_pc", CDB_pc, 32'd0);
        chk("rst_ready", 32'(RS_ready), 32'd1);

        // Back-to-back ALU ops on consecutive cycles.
        @(posedge clk); #1;
        RS_opcode = OP_ADDI; lhs = 32'd5; imm = 32'hFFFF_FFF9; pc = 32'h40; ROB_entry = 4'd1; RS_sgn = 1'b1;
        @(posedge clk); #1;
        RS_opcode = OP_SRA; lhs = 32'h8000_0000; rhs = 32'd4; ROB_entry = 4'd2;
        @(negedge clk);
        chk("b2b_sgn1", 32'(CDB_sgn), 32'd1);
        chk("b2b_res1", result, 32'hFFFF_FFFE);
        chk("b2b_ready1", 32'(RS_ready), 32'd1);
        @(posedge clk); #1;
        RS_sgn = 1'b0;
        @(negedge clk);
        chk("b2b_sgn2", 32'(CDB_sgn), 32'd1);
        chk("b2b_res2", result, 32'hF800_0000);
        chk("b2b_tag2", 32'(CDB_ROB_name), 32'd2);
        chk("b2b_ready2", 32'(RS_ready), 32'd1);

        run_op("blt", OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd3, 32'd1, 32'h120, 1, 0);
        run_op("jalr", OP_JALR, 32'h203, 32'd0, 32'd0, 32'h400, 4'd4, 32'h404, 32'h202, 1, 0);
        run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h500, 4'd5, 32'h4000_0000, 32'h504, MUL_LAT, 0);
        run_op("div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'h600, 4'd6, 32'hFFFF_FFF2, 32'h604, XLEN + 1, 0);
        run_op("rem", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'd0, 32'h610, 4'd7, 32'hFFFF_FFFE, 32'h614, XLEN + 1, 0);
        run_op("div0", OP_DIV, 32'd1234, 32'd0, 32'd0, 32'h620, 4'd8, 32'hFFFF_FFFF, 32'h624, 1, 0);
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h630, 4'd9, 32'h8000_0000, 32'h634, 1, 0);
        run_op("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h640, 4'd10, 32'd0, 32'h644, 1, 0);
        run_op("undef", 6'd63, 32'd9, 32'd9, 32'd9, 32'h650, 4'd11, 32'd0, 32'd0, 1, 0);
        run_op("divstall", OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'h660, 4'd12, 32'd333, 32'h664, XLEN + 6, 5);

        // A pulse stalled by rdy stays visible, then lasts one enabled cycle.
        @(posedge clk); #1;
        RS_opcode = OP_ADD; lhs = 32'd1; rhs = 32'd2; pc = 32'h700; ROB_entry = 4'd13; RS_sgn = 1'b1;
        @(posedge clk); #1;
        RS_sgn = 1'b0; rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_held_sgn", 32'(CDB_sgn), 32'd1);
        chk("stall_held_res", result, 32'd3);
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_release", 32'(CDB_sgn), 32'd0);

        // Flush mid-divide: no result, unit ready again.
        @(posedge clk); #1;
        RS_opcode = OP_DIVU; lhs = 32'd1000; rhs = 32'd3; pc = 32'h800; ROB_entry = 4'd14; RS_sgn = 1'b1;
        @(posedge clk); #1;
        RS_sgn = 1'b0;
        repeat (9) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_sgn", 32'(CDB_sgn), 32'd0);
        chk("clr_ready", 32'(RS_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (CDB_sgn) cnt++;
        end
        chk("clr_no_result", cnt, 0);

        // An issue in the same cycle as clear is dropped.
        @(posedge clk); #1;
        RS_opcode = OP_ADD; lhs = 32'd4; rhs = 32'd4; RS_sgn = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        RS_sgn = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("clr_drop_issue", 32'(CDB_sgn), 32'd0);

        for (int n = 0; n < 150; n++) begin
            op = 6'($urandom_range(0, 40));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 6))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                3: b = a;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            i  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            p  = $urandom & 32'hFFFF_FFFC;
            tg = 4'($urandom_range(0, 15));
            model(op, a, b, i, p, er, en, el);
            run_op($sformatf("rnd_op%0d", op), op, a, b, i, p, tg, er, en, el, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, registered successor to the combinational integer ALU in the Tomasulo core. It sits between the arithmetic reservation station and the CDB. It executes all RV32I ALU, branch and jump ops with 1-cycle latency. It adds RV32M multiply (fixed `MUL_LAT`) and iterative divide/remainder, with a ready handshake back to the RS and a flush on mispredict.

## Interface
- `XLEN`, 32: datapath width.
- `ROB_W`, 4: ROB index width; must match `` `ROBENTRY``.
- `MUL_LAT`, 3: multiply latency in cycles; must be ≥1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all registers hold.
- `clear` in 1: ROB flush; aborts in-flight work.
- `RS_sgn` in 1: issue valid.
- `RS_ready` out 1: unit can accept; equals `state==IDLE && !rst`.
- `RS_opcode` in 6: op code from `defines.v`.
- `lhs`, `rhs`, `imm`, `pc` in `XLEN`: operands.
- `ROB_entry` in `ROB_W`: destination tag.
- `CDB_sgn` out 1: result valid, one-cycle pulse.
- `CDB_ROB_name` out `ROB_W`: tag of the result.
- `result` out `XLEN`: rd value, or taken flag for branches.
- `CDB_pc_init` out `XLEN`: pc of the instruction.
- `CDB_pc` out `XLEN`: next pc.

## Operation
- Accept happens when `rdy && RS_sgn && RS_ready && !clear`. On accept, latch `ROB_entry` and `pc`.
- ALU ops:
  - ADD/SUB/logic/SLT* as RV32I; SLTIU compares `lhs` against `imm` unsigned.
  - SLL/SRL: logical shifts. SRA: arithmetic shift. Shift amount is `rhs[4:0]`, or `imm[4:0]` for immediate forms.
  - LUI gives `imm`; AUIPC gives `pc+imm`.
  - `CDB_pc = pc+4` unless overridden below.
- Branches: `result=1` when taken and then `CDB_pc=pc+imm`; otherwise `result=0`.
- JAL: `result=pc+4`, `CDB_pc=pc+imm`.
- JALR: `result=pc+4`, `CDB_pc=(lhs+imm)&~1`.
- Undefined opcode: `result=0`, `CDB_pc=0`.
- MUL: low half of the product. MULH: high half, signed×signed. MULHSU: high half, signed×unsigned. MULHU: high half, unsigned×unsigned.
- DIV/DIVU give the quotient, REM/REMU the remainder. Signed forms truncate toward zero; the remainder takes the sign of the dividend.
- Divide by zero: quotient = all-ones, remainder = `lhs`. Latency 1.
- Signed overflow (`-2^(XLEN-1) / -1`): quotient = `lhs`, remainder = 0. Latency 1.
- FSM states:
  - IDLE: on accepting an ALU op or a divide corner case, stay in IDLE. On accepting a MUL* op, go to MUL_WAIT when `MUL_LAT>1`; otherwise stay. On accepting any other DIV/REM op, go to DIV_RUN.
  - MUL_WAIT: count down `MUL_LAT-1` cycles, then return to IDLE.
  - DIV_RUN: restoring radix-2, one quotient bit per cycle for `XLEN` cycles, then return to IDLE.
- `clear`: next edge sets state IDLE and `CDB_sgn=0`. Any in-flight result is discarded and any issue in the same cycle is dropped.
- Reset: state IDLE; every output register is 0, i.e. `CDB_sgn`, `CDB_ROB_name`, `result`, `CDB_pc_init`, `CDB_pc`.

## Timing
- Latency is counted from the accept edge E0.
  - ALU, branch, jump and divide corner cases: `CDB_sgn` high in the cycle after E0.
  - MUL*: `CDB_sgn` high in cycle `MUL_LAT` after E0.
  - DIV/REM: `CDB_sgn` high in cycle `XLEN+1` after E0.
- Throughput: one ALU op per cycle. `RS_ready` is low from E0 until the cycle in which the multi-cycle result is on the CDB. The next accept can happen at the end of that cycle.
- `CDB_sgn` lasts exactly one enabled cycle. There is no CDB backpressure.
- `rdy` low freezes the counter, FSM and outputs. A pulse stalled by `rdy` stays visible until `rdy` returns.
- `clear` and completion in the same cycle: `clear` wins and `CDB_sgn` is 0 next cycle.
- `rst` overrides `clear` and `rdy`.

## Structure
- `defines.v`: existing ALU, branch and jump codes plus new `` `MUL``, `` `MULH``, `` `MULHSU``, `` `MULHU``, `` `DIV``, `` `DIVU``, `` `REM``, `` `REMU``. Also the FSM state encodings (`` `EU_IDLE``, `` `EU_MUL``, `` `EU_DIV``).
- Sub-module `div_iter`: start/busy/done interface, unsigned `XLEN`-bit restoring divider. Sign fix-up and corner cases are handled in `exec_unit`.
- The multiply uses one `2*XLEN`-bit product register, computed at accept and held for `MUL_LAT`.

## Test plan
- Reset: hold `rst` 2 cycles, then issue nothing -> all outputs 0 and `RS_ready=1`.
- Back-to-back ADDI `lhs=5,imm=-7` then SRA `lhs=0x80000000,rhs=4` -> consecutive cycles give 0xFFFFFFFE then 0xF8000000, and `RS_ready` never drops.
- BLT `lhs=-1,rhs=1,pc=0x100,imm=0x20` -> `result=1`, `CDB_pc=0x120`. JALR `lhs=0x203,imm=0` -> `CDB_pc=0x202`, `result=pc+4`.
- MULH `0x80000000×0x80000000` -> 0x40000000 at cycle `MUL_LAT`. DIV `-100/7` -> 0xFFFFFFF2 at cycle 33, and REM gives 0xFFFFFFFE.
- DIV `x/0` -> 0xFFFFFFFF at latency 1. DIV `0x80000000/-1` -> 0x80000000 and REM gives 0, both at latency 1.
- DIVU issued, `clear` asserted at cycle 10 -> no `CDB_sgn`, `RS_ready=1` next cycle. Then `rdy` low for 5 cycles mid-DIV -> completion delayed by exactly 5.
